// File: rtl/bcd_timekeeper.sv
// Clock-enabled BCD hh:mm:ss time base: wall clock, stopwatch and countdown timer.
// Define BCD_TIMEKEEPER_ALARM_EN to add the alarm comparator (alarm_set/alarm_time/alarm_hit).
module bcd_timekeeper #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned HOUR_MAX = 23
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        run,
    input  logic [1:0]  mode,
    input  logic        clear,
    input  logic        load,
    input  logic [19:0] load_time,
`ifdef BCD_TIMEKEEPER_ALARM_EN
    input  logic        alarm_set,
    input  logic [19:0] alarm_time,
    output logic        alarm_hit,
`endif
    output logic [19:0] time_out,
    output logic        tick,
    output logic        expired,
    output logic        load_err,
    output logic        running
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    localparam logic [1:0] HT_MAX = 2'(HOUR_MAX / 10);
    localparam logic [3:0] HU_MAX = 4'(HOUR_MAX % 10);
    localparam logic [19:0] TIME_MAX = {HT_MAX, HU_MAX, 3'd5, 4'd9, 3'd5, 4'd9};

    localparam logic [1:0] MODE_CLOCK = 2'b00;
    localparam logic [1:0] MODE_WATCH = 2'b01;
    localparam logic [1:0] MODE_TIMER = 2'b10;
    localparam logic [1:0] MODE_HOLD  = 2'b11;

    localparam logic [1:0] ST_STOP = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    function automatic logic time_valid(input logic [19:0] t);
        logic [5:0] hours;
        hours = 6'(t[19:18]) * 6'd10 + 6'(t[17:14]);
        return (t[3:0] <= 4'd9) && (t[6:4] <= 3'd5) && (t[10:7] <= 4'd9) &&
               (t[13:11] <= 3'd5) && (t[17:14] <= 4'd9) && (hours <= 6'(HOUR_MAX));
    endfunction

    // Full carry ripple in one step, so time_out never shows an intermediate value.
    function automatic logic [19:0] bcd_inc(input logic [19:0] t);
        logic [1:0] ht;
        logic [3:0] hu;
        logic [2:0] mt;
        logic [3:0] mu;
        logic [2:0] st;
        logic [3:0] su;
        {ht, hu, mt, mu, st, su} = t;
        if (su < 4'd9) begin
            su = su + 4'd1;
        end else begin
            su = '0;
            if (st < 3'd5) begin
                st = st + 3'd1;
            end else begin
                st = '0;
                if (mu < 4'd9) begin
                    mu = mu + 4'd1;
                end else begin
                    mu = '0;
                    if (mt < 3'd5) begin
                        mt = mt + 3'd1;
                    end else begin
                        mt = '0;
                        if (ht >= HT_MAX && hu >= HU_MAX) begin
                            ht = '0;
                            hu = '0;
                        end else if (hu >= 4'd9) begin
                            hu = '0;
                            ht = ht + 2'd1;
                        end else begin
                            hu = hu + 4'd1;
                        end
                    end
                end
            end
        end
        return {ht, hu, mt, mu, st, su};
    endfunction

    function automatic logic [19:0] bcd_dec(input logic [19:0] t);
        logic [1:0] ht;
        logic [3:0] hu;
        logic [2:0] mt;
        logic [3:0] mu;
        logic [2:0] st;
        logic [3:0] su;
        {ht, hu, mt, mu, st, su} = t;
        if (su != 4'd0) begin
            su = su - 4'd1;
        end else begin
            su = 4'd9;
            if (st != 3'd0) begin
                st = st - 3'd1;
            end else begin
                st = 3'd5;
                if (mu != 4'd0) begin
                    mu = mu - 4'd1;
                end else begin
                    mu = 4'd9;
                    if (mt != 3'd0) begin
                        mt = mt - 3'd1;
                    end else begin
                        mt = 3'd5;
                        if (hu != 4'd0) begin
                            hu = hu - 4'd1;
                        end else if (ht != 2'd0) begin
                            hu = 4'd9;
                            ht = ht - 2'd1;
                        end else begin
                            hu = HU_MAX;
                            ht = HT_MAX;
                        end
                    end
                end
            end
        end
        return {ht, hu, mt, mu, st, su};
    endfunction

    logic [1:0]    state_q, state_d;
    logic [19:0]   time_q, time_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          expired_q, expired_d;
    logic          load_err_q, load_err_d;
    logic          running_q, running_d;

    logic [19:0] time_up;
    logic [19:0] time_down;
    logic        load_ok;
    logic        presc_wrap;
    logic        terminal;

    assign time_up    = bcd_inc(time_q);
    assign time_down  = bcd_dec(time_q);
    assign load_ok    = time_valid(load_time);
    assign presc_wrap = (state_q == ST_RUN) && (presc_q == PRESC_LAST);

    always_comb begin
        time_d     = time_q;
        presc_d    = presc_q;
        tick_d     = 1'b0;
        expired_d  = 1'b0;
        load_err_d = 1'b0;
        terminal   = 1'b0;

        if (state_q == ST_RUN) begin
            presc_d = presc_wrap ? '0 : presc_q + PW'(1);
        end

        if (clear) begin
            time_d  = '0;
            presc_d = '0;
        end else if (load) begin
            if (load_ok) begin
                time_d  = load_time;
                presc_d = '0;
            end else begin
                load_err_d = 1'b1;
            end
        end else if (presc_wrap) begin
            // Mode is sampled here, so a mode change during RUN applies at the next tick.
            case (mode)
                MODE_CLOCK: begin
                    time_d = time_up;
                    tick_d = 1'b1;
                end
                MODE_WATCH: begin
                    tick_d = 1'b1;
                    if (time_q == TIME_MAX) begin
                        terminal  = 1'b1;
                        expired_d = 1'b1;
                    end else begin
                        time_d = time_up;
                    end
                end
                MODE_TIMER: begin
                    // Already at zero (e.g. cleared while running): stop without a borrow.
                    if (time_q == '0) begin
                        terminal = 1'b1;
                    end else begin
                        time_d = time_down;
                        tick_d = 1'b1;
                        if (time_down == '0) begin
                            terminal  = 1'b1;
                            expired_d = 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (run && mode != MODE_HOLD && !(mode == MODE_TIMER && time_d == '0)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (terminal) begin
                    state_d = ST_DONE;
                end else if (!run || mode == MODE_HOLD) begin
                    state_d = ST_STOP;
                end
            end
            ST_DONE: begin
                if (!run || clear || load) begin
                    state_d = ST_STOP;
                end
            end
            default: state_d = ST_STOP;
        endcase
        running_d = (state_d == ST_RUN);
    end

`ifdef BCD_TIMEKEEPER_ALARM_EN
    logic [19:0] alarm_q, alarm_d;
    logic        alarm_valid_q, alarm_valid_d;
    logic        alarm_hit_q, alarm_hit_d;
    logic        alarm_ok;
    logic        alarm_err;

    assign alarm_ok = time_valid(alarm_time);

    always_comb begin
        alarm_d       = alarm_q;
        alarm_valid_d = alarm_valid_q;
        alarm_err     = 1'b0;
        if (alarm_set) begin
            if (alarm_ok) begin
                alarm_d       = alarm_time;
                alarm_valid_d = 1'b1;
            end else begin
                alarm_err = 1'b1;
            end
        end
        // Only a tick that actually moves the time can hit; load/clear never do.
        alarm_hit_d = alarm_valid_q && tick_d && (time_d != time_q) && (time_d == alarm_q);
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            alarm_q       <= '0;
            alarm_valid_q <= 1'b0;
            alarm_hit_q   <= 1'b0;
        end else begin
            alarm_q       <= alarm_d;
            alarm_valid_q <= alarm_valid_d;
            alarm_hit_q   <= alarm_hit_d;
        end
    end

    assign alarm_hit = alarm_hit_q;
`else
    logic alarm_err;
    assign alarm_err = 1'b0;
`endif

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q    <= ST_STOP;
            time_q     <= '0;
            presc_q    <= '0;
            tick_q     <= 1'b0;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
            running_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            expired_q  <= expired_d;
            load_err_q <= load_err_d | alarm_err;
            running_q  <= running_d;
        end
    end

    assign time_out = time_q;
    assign tick     = tick_q;
    assign expired  = expired_q;
    assign load_err = load_err_q;
    assign running  = running_q;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// Directed self-checking bench for bcd_timekeeper with TICK_DIV=4, HOUR_MAX=23.
module tb_bcd_timekeeper;

    logic        clk_sys;
    logic        rst;
    logic        run;
    logic [1:0]  mode;
    logic        clear;
    logic        load;
    logic [19:0] load_time;
    logic [19:0] time_out;
    logic        tick;
    logic        expired;
    logic        load_err;
    logic        running;
`ifdef BCD_TIMEKEEPER_ALARM_EN
    logic        alarm_set;
    logic [19:0] alarm_time;
    logic        alarm_hit;
`endif

    int n_checks = 0;
    int n_errors = 0;

    bcd_timekeeper #(
        .TICK_DIV(4),
        .HOUR_MAX(23)
    ) u_dut (
        .clk_sys   (clk_sys),
        .rst       (rst),
        .run       (run),
        .mode      (mode),
        .clear     (clear),
        .load      (load),
        .load_time (load_time),
`ifdef BCD_TIMEKEEPER_ALARM_EN
        .alarm_set (alarm_set),
        .alarm_time(alarm_time),
        .alarm_hit (alarm_hit),
`endif
        .time_out  (time_out),
        .tick      (tick),
        .expired   (expired),
        .load_err  (load_err),
        .running   (running)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    function automatic logic [19:0] pack_d(input int ht, input int hu, input int mt,
                                           input int mu, input int st, input int su);
        return {2'(ht), 4'(hu), 3'(mt), 4'(mu), 3'(st), 4'(su)};
    endfunction

    function automatic logic [19:0] pack(input int h, input int m, input int s);
        return pack_d(h / 10, h % 10, m / 10, m % 10, s / 10, s % 10);
    endfunction

    task automatic check_eq(input string tag, input logic [19:0] got, input logic [19:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    initial begin
        rst       = 1'b1;
        run       = 1'b0;
        mode      = 2'b00;
        clear     = 1'b0;
        load      = 1'b0;
        load_time = '0;
`ifdef BCD_TIMEKEEPER_ALARM_EN
        alarm_set  = 1'b0;
        alarm_time = '0;
`endif
        step(2);
        check_eq("rst_time", time_out, 20'd0);
        check_eq("rst_tick", 20'(tick), 20'd0);
        check_eq("rst_expired", 20'(expired), 20'd0);
        check_eq("rst_load_err", 20'(load_err), 20'd0);
        check_eq("rst_running", 20'(running), 20'd0);
        rst = 1'b0;

        // Clock mode wrap 23:59:58 -> 23:59:59 -> 00:00:00
        clear = 1'b1;
        step(1);
        clear     = 1'b0;
        load      = 1'b1;
        load_time = pack(23, 59, 58);
        run       = 1'b1;
        step(1);
        load = 1'b0;
        check_eq("clk_load", time_out, pack(23, 59, 58));
        check_eq("clk_running", 20'(running), 20'd1);
        step(3);
        check_eq("clk_no_early_tick", 20'(tick), 20'd0);
        step(1);
        check_eq("clk_tick1", 20'(tick), 20'd1);
        check_eq("clk_time1", time_out, pack(23, 59, 59));
        step(1);
        check_eq("clk_tick_pulse", 20'(tick), 20'd0);
        step(3);
        check_eq("clk_tick2", 20'(tick), 20'd1);
        check_eq("clk_wrap", time_out, pack(0, 0, 0));
        check_eq("clk_no_expired", 20'(expired), 20'd0);
        check_eq("clk_still_run", 20'(running), 20'd1);

        // Timer countdown with borrow, then terminal count
        mode      = 2'b10;
        load      = 1'b1;
        load_time = pack(0, 1, 0);
        step(1);
        load = 1'b0;
        check_eq("tmr_load", time_out, pack(0, 1, 0));
        step(4);
        check_eq("tmr_borrow", time_out, pack(0, 0, 59));
        check_eq("tmr_tick", 20'(tick), 20'd1);
        load      = 1'b1;
        load_time = pack(0, 0, 2);
        step(1);
        load = 1'b0;
        step(4);
        check_eq("tmr_one", time_out, pack(0, 0, 1));
        check_eq("tmr_not_expired", 20'(expired), 20'd0);
        step(4);
        check_eq("tmr_zero", time_out, pack(0, 0, 0));
        check_eq("tmr_expired", 20'(expired), 20'd1);
        check_eq("tmr_done_running", 20'(running), 20'd0);
        step(1);
        check_eq("tmr_expired_pulse", 20'(expired), 20'd0);
        step(4);
        check_eq("tmr_hold", time_out, pack(0, 0, 0));
        check_eq("tmr_done_stays", 20'(running), 20'd0);
        run = 1'b0;
        step(1);
        run = 1'b1;
        step(2);
        check_eq("tmr_zero_no_start", 20'(running), 20'd0);

        // Stopwatch saturation
        mode      = 2'b01;
        load      = 1'b1;
        load_time = pack(23, 59, 59);
        step(1);
        load = 1'b0;
        check_eq("sw_running", 20'(running), 20'd1);
        step(4);
        check_eq("sw_hold", time_out, pack(23, 59, 59));
        check_eq("sw_expired", 20'(expired), 20'd1);
        check_eq("sw_done", 20'(running), 20'd0);
        step(1);
        check_eq("sw_expired_pulse", 20'(expired), 20'd0);

        // Rejected loads
        run = 1'b0;
        step(1);
        load      = 1'b1;
        load_time = pack_d(0, 0, 0, 0, 6, 10);
        step(1);
        load = 1'b0;
        check_eq("ld_bad_ss_err", 20'(load_err), 20'd1);
        check_eq("ld_bad_ss_time", time_out, pack(23, 59, 59));
        step(1);
        check_eq("ld_err_pulse", 20'(load_err), 20'd0);
        load      = 1'b1;
        load_time = pack(24, 0, 0);
        step(1);
        load = 1'b0;
        check_eq("ld_bad_hh_err", 20'(load_err), 20'd1);
        check_eq("ld_bad_hh_time", time_out, pack(23, 59, 59));

        // Load coincident with a tick
        mode  = 2'b00;
        clear = 1'b1;
        run   = 1'b1;
        step(1);
        clear = 1'b0;
        step(3);
        load      = 1'b1;
        load_time = pack(12, 34, 56);
        step(1);
        load = 1'b0;
        check_eq("ld_tick_time", time_out, pack(12, 34, 56));
        check_eq("ld_tick_no_tick", 20'(tick), 20'd0);
        step(4);
        check_eq("ld_next_tick", 20'(tick), 20'd1);
        check_eq("ld_next_time", time_out, pack(12, 34, 57));

        // Pause keeps the prescaler fraction
        step(2);
        run = 1'b0;
        step(1);
        check_eq("pause_stop", 20'(running), 20'd0);
        step(9);
        check_eq("pause_no_tick", 20'(tick), 20'd0);
        check_eq("pause_time", time_out, pack(12, 34, 57));
        run = 1'b1;
        step(1);
        check_eq("resume_running", 20'(running), 20'd1);
        check_eq("resume_no_tick", 20'(tick), 20'd0);
        step(1);
        check_eq("resume_tick", 20'(tick), 20'd1);
        check_eq("resume_time", time_out, pack(12, 34, 58));

        // Clear beats load
        clear     = 1'b1;
        load      = 1'b1;
        load_time = pack(5, 5, 5);
        step(1);
        clear = 1'b0;
        load  = 1'b0;
        check_eq("clr_prio_time", time_out, pack(0, 0, 0));
        check_eq("clr_prio_no_err", 20'(load_err), 20'd0);

        // Async reset mid-count
        step(4);
        check_eq("pre_rst_tick", 20'(tick), 20'd1);
        check_eq("pre_rst_time", time_out, pack(0, 0, 1));
        #2;
        rst = 1'b1;
        #1;
        check_eq("async_rst_time", time_out, 20'd0);
        check_eq("async_rst_tick", 20'(tick), 20'd0);
        check_eq("async_rst_running", 20'(running), 20'd0);
        step(1);
        rst = 1'b0;

`ifdef BCD_TIMEKEEPER_ALARM_EN
        begin
            int hits;
            int hit_at;
            alarm_time = pack_d(0, 0, 0, 0, 7, 0);
            alarm_set  = 1'b1;
            run        = 1'b0;
            step(1);
            alarm_set = 1'b0;
            check_eq("alm_bad_err", 20'(load_err), 20'd1);
            alarm_time = pack(0, 0, 3);
            alarm_set  = 1'b1;
            clear      = 1'b1;
            mode       = 2'b00;
            run        = 1'b1;
            step(1);
            alarm_set = 1'b0;
            clear     = 1'b0;
            hits      = 0;
            hit_at    = 0;
            for (int i = 1; i <= 13; i++) begin
                step(1);
                if (alarm_hit) begin
                    hits++;
                    hit_at = i;
                end
            end
            check_eq("alm_hits", 20'(hits), 20'd1);
            check_eq("alm_hit_edge", 20'(hit_at), 20'd12);
            load      = 1'b1;
            load_time = pack(0, 0, 3);
            step(1);
            load = 1'b0;
            check_eq("alm_load_no_hit", 20'(alarm_hit), 20'd0);
            #2;
            rst = 1'b1;
            #1;
            check_eq("alm_rst_hit", 20'(alarm_hit), 20'd0);
            check_eq("alm_rst_time", time_out, 20'd0);
            step(1);
            rst = 1'b0;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
